// File: rtl/mux_2a1_serial_pkg.sv
// Shared constants for the 2-lane serial mux.
package mux_2a1_serial_pkg;

  localparam int unsigned BW_DEFAULT = 4;

  // Lane identifiers. They double as the value of the "next lane to emit" selector.
  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_t;

  function automatic lane_t other_lane(input lane_t l);
    return (l == LANE0) ? LANE1 : LANE0;
  endfunction

endpackage

// File: rtl/mux_2a1_serial_lane_buffer.sv
// One-entry holding register with a valid/ready input handshake.
// ready depends only on the registered full flag.
module lane_buffer
  import mux_2a1_serial_pkg::*;
#(
  parameter int unsigned BW = BW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [BW-1:0] data_in,
  input  logic          valid_in,
  output logic          ready_in,
  input  logic          drain,
  output logic          full,
  output logic [BW-1:0] data
);

  // Capture a word when the buffer is empty; release it when the top drains it.
  // Accept and drain never overlap: accept needs !full, drain needs full.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
    end else if (valid_in && !full) begin
      data <= data_in;
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

  // The buffer can accept whenever it is empty.
  always_comb begin
    ready_in = !full;
  end

endmodule

// File: rtl/mux_2a1_serial.sv
// Merges two BW-bit lanes into one registered, valid-qualified stream,
// emitting in strict alternation starting with lane 0.
module mux_2a1_serial
  import mux_2a1_serial_pkg::*;
#(
  parameter int unsigned BW = BW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [BW-1:0] data_in0,
  input  logic          valid_in0,
  output logic          ready_in0,
  input  logic [BW-1:0] data_in1,
  input  logic          valid_in1,
  output logic          ready_in1,
  output logic [BW-1:0] data_out,
  output logic          valid_out
);

  lane_t         sel;
  logic          full0;
  logic          full1;
  logic [BW-1:0] buf0;
  logic [BW-1:0] buf1;
  logic          drain0;
  logic          drain1;
  logic          emit;
  logic [BW-1:0] emit_data;

  lane_buffer #(.BW(BW)) u_lane0 (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in0),
    .valid_in (valid_in0),
    .ready_in (ready_in0),
    .drain    (drain0),
    .full     (full0),
    .data     (buf0)
  );

  lane_buffer #(.BW(BW)) u_lane1 (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in1),
    .valid_in (valid_in1),
    .ready_in (ready_in1),
    .drain    (drain1),
    .full     (full1),
    .data     (buf1)
  );

  // Only the selected lane may emit; the other lane waits its turn even when full.
  always_comb begin
    drain0    = 1'b0;
    drain1    = 1'b0;
    emit_data = buf0;
    if (sel == LANE0) begin
      drain0    = full0;
      emit_data = buf0;
    end else begin
      drain1    = full1;
      emit_data = buf1;
    end
    emit = drain0 | drain1;
  end

  // Output register and turn selector; on a stall data_out holds and sel stays put.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel       <= LANE0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= emit;
      if (emit) begin
        data_out <= emit_data;
        sel      <= other_lane(sel);
      end
    end
  end

endmodule

// File: tb/tb_mux_2a1_serial.sv
// Self-checking bench for mux_2a1_serial: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
module tb_mux_2a1_serial;

  localparam int unsigned BW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] data_in0;
  logic          valid_in0;
  logic          ready_in0;
  logic [BW-1:0] data_in1;
  logic          valid_in1;
  logic          ready_in1;
  logic [BW-1:0] data_out;
  logic          valid_out;

  always #5 clk = ~clk;

  mux_2a1_serial #(.BW(BW)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in0  (data_in0),
    .valid_in0 (valid_in0),
    .ready_in0 (ready_in0),
    .data_in1  (data_in1),
    .valid_in1 (valid_in1),
    .ready_in1 (ready_in1),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each lane is a queue of at most one word, plus whose turn it is.
  logic [BW-1:0] mq0[$];
  logic [BW-1:0] mq1[$];
  bit            mturn;
  bit            mvalid;
  logic [BW-1:0] mdata;
  bit            known = 1'b0;

  // Sender-side sources and the words actually observed on the output.
  logic [BW-1:0] src0[$];
  logic [BW-1:0] src1[$];
  logic [BW-1:0] emitted[$];
  int unsigned   gate_pct = 100;

  task automatic model_step(output bit a0, output bit a1);
    a0 = !reset && valid_in0 && (mq0.size() == 0);
    a1 = !reset && valid_in1 && (mq1.size() == 0);
    if (reset) begin
      mq0.delete();
      mq1.delete();
      mturn  = 1'b0;
      mvalid = 1'b0;
      mdata  = '0;
    end else begin
      mvalid = 1'b0;
      if (!mturn && mq0.size() != 0) begin
        mdata  = mq0.pop_front();
        mvalid = 1'b1;
        mturn  = 1'b1;
      end else if (mturn && mq1.size() != 0) begin
        mdata  = mq1.pop_front();
        mvalid = 1'b1;
        mturn  = 1'b0;
      end
      if (a0) mq0.push_back(data_in0);
      if (a1) mq1.push_back(data_in1);
    end
  endtask

  // One clock cycle: drive inputs, check ready, advance model, check outputs.
  task automatic cycle(input bit use_src);
    bit a0, a1, was_reset;
    if (use_src) begin
      valid_in0 = (src0.size() > 0) && ($urandom_range(99) < gate_pct);
      data_in0  = valid_in0 ? src0[0] : BW'($urandom);
      valid_in1 = (src1.size() > 0) && ($urandom_range(99) < gate_pct);
      data_in1  = valid_in1 ? src1[0] : BW'($urandom);
    end
    #1;
    if (known) begin
      chk("ready_in0", 32'(ready_in0), 32'(mq0.size() == 0));
      chk("ready_in1", 32'(ready_in1), 32'(mq1.size() == 0));
    end
    was_reset = reset;
    model_step(a0, a1);
    if (use_src) begin
      if (a0) void'(src0.pop_front());
      if (a1) void'(src1.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    if (was_reset) known = 1'b1;
    chk("valid_out", 32'(valid_out), 32'(mvalid));
    chk("data_out", 32'(data_out), 32'(mdata));
    if (valid_out === 1'b1) emitted.push_back(data_out);
  endtask

  task automatic do_reset(input int unsigned n);
    reset     = 1'b1;
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    repeat (n) cycle(1'b0);
    reset = 1'b0;
  endtask

  logic [BW-1:0] exp2[8];
  int            d_seen;

  initial begin
    reset     = 1'b1;
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    data_in0  = '0;
    data_in1  = '0;

    // 1: reset held 3 cycles with lane 0 presenting F; nothing captured.
    valid_in0 = 1'b1;
    data_in0  = 4'hF;
    repeat (3) cycle(1'b0);
    chk("t1_rst_ready0", 32'(ready_in0), 32'd1);
    reset     = 1'b0;
    valid_in0 = 1'b0;
    repeat (3) cycle(1'b0);
    chk("t1_nothing_emitted", 32'(emitted.size()), 32'd0);

    // 2: both lanes streaming -> full-rate alternating output.
    emitted.delete();
    src0 = '{4'h8, 4'hE, 4'hA, 4'h6};
    src1 = '{4'h4, 4'h7, 4'h5, 4'h3};
    exp2 = '{4'h8, 4'h4, 4'hE, 4'h7, 4'hA, 4'h5, 4'h6, 4'h3};
    repeat (11) cycle(1'b1);
    chk("t2_count", 32'(emitted.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < emitted.size()) chk("t2_word", 32'(emitted[i]), 32'(exp2[i]));
    end

    // 3: lane 1 idle stalls the stream; lane 0 holds its second word.
    emitted.delete();
    src0 = '{4'h1, 4'h2};
    repeat (4) cycle(1'b1);
    chk("t3_stall_ready0", 32'(ready_in0), 32'd0);
    chk("t3_stall_valid", 32'(valid_out), 32'd0);
    src1 = '{4'h9};
    repeat (4) cycle(1'b1);
    chk("t3_count", 32'(emitted.size()), 32'd3);
    if (emitted.size() == 3) begin
      chk("t3_w0", 32'(emitted[0]), 32'h1);
      chk("t3_w1", 32'(emitted[1]), 32'h9);
      chk("t3_w2", 32'(emitted[2]), 32'h2);
    end

    // 4: lane 1 arrives early but lane 0 still goes first.
    do_reset(1);
    emitted.delete();
    src1 = '{4'hC};
    repeat (2) cycle(1'b1);
    src0 = '{4'hB};
    repeat (4) cycle(1'b1);
    chk("t4_count", 32'(emitted.size()), 32'd2);
    if (emitted.size() == 2) begin
      chk("t4_first", 32'(emitted[0]), 32'hB);
      chk("t4_second", 32'(emitted[1]), 32'hC);
    end

    // 5: reset while lane 0 holds D out of turn; D must be lost.
    do_reset(1);
    emitted.delete();
    src0 = '{4'h3};
    repeat (2) cycle(1'b1);
    src0 = '{4'hD};
    repeat (3) cycle(1'b1);
    chk("t5_buf0_full", 32'(ready_in0), 32'd0);
    do_reset(1);
    chk("t5_rst_data", 32'(data_out), 32'd0);
    src0 = '{4'h7};
    src1 = '{4'h6};
    repeat (5) cycle(1'b1);
    d_seen = 0;
    foreach (emitted[i]) if (emitted[i] == 4'hD) d_seen++;
    chk("t5_d_never_emitted", 32'(d_seen), 32'd0);
    chk("t5_count", 32'(emitted.size()), 32'd3);

    // 6: stalled lane 1 sender changes data; buffered word wins.
    do_reset(1);
    emitted.delete();
    src1 = '{4'h5};
    repeat (2) cycle(1'b1);
    valid_in0 = 1'b0;
    valid_in1 = 1'b1;
    data_in1  = 4'hA;
    repeat (2) cycle(1'b0);
    valid_in1 = 1'b0;
    src0 = '{4'h7};
    repeat (4) cycle(1'b1);
    chk("t6_count", 32'(emitted.size()), 32'd2);
    if (emitted.size() == 2) begin
      chk("t6_first", 32'(emitted[0]), 32'h7);
      chk("t6_second", 32'(emitted[1]), 32'h5);
    end

    // Randomized traffic with occasional mid-stream resets.
    do_reset(1);
    gate_pct = 70;
    for (int n = 0; n < 500; n++) begin
      if (src0.size() < 2) src0.push_back(BW'($urandom));
      if (src1.size() < 2) src1.push_back(BW'($urandom));
      reset = ($urandom_range(99) < 3);
      cycle(1'b1);
    end
    reset = 1'b0;
    gate_pct = 100;
    repeat (10) cycle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
